stream_output_fifo: RTL
=======================

Name: stream_output_fifo

Overview:
- Parametrised successor to the accelerator's output FIFO: a synchronous single-clock FIFO with valid/ready handshakes on both sides and first-word-fall-through output.
- Adds what the previous generation lacks:
  - full use of all DEPTH entries;
  - true empty/valid and full/ready handling;
  - occupancy count and programmable almost-full/almost-empty flags;
  - synchronous flush;
  - a clearable high-water mark.
- Sits between the accelerator datapath and the AXI/ACP write-out logic.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL (1..DEPTH).
- AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL (0..DEPTH-1).
- CW (derived, not overridable) = clog2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents, count and pointers.
- hwm_clear  in  1  synchronous clear of high-water mark.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DATA_WIDTH  write payload.
- out_valid  out  1  head word is valid.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_WIDTH  head word, first-word-fall-through.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- high_water  out  CW  maximum count since the last reset/flush/hwm_clear.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - pointers, count and high_water = 0;
  - in_ready=1, out_valid=0, almost_full=0, almost_empty=1.
  - Storage contents are not reset.
  - Reset mid-transfer discards all data immediately; no handshake completes in that cycle.
- Pointers: rd_ptr and wr_ptr are CW bits wide (extra wrap bit).
  - Index = low clog2(DEPTH) bits; wrap-around occurs naturally at DEPTH.
  - Empty = pointers equal.
  - Full = indexes equal and wrap bits differ.
  - All DEPTH entries are usable.
- Push: push = in_valid & in_ready. in_ready = !full (registered-state-derived; no combinational path from out_ready).
  - On push: mem[wr_idx] <= in_data; wr_ptr+1.
- Pop: pop = out_valid & out_ready. out_valid = !empty.
  - out_data = mem[rd_idx], combinational from storage (zero latency, FWFT).
  - On pop: rd_ptr+1.
  - out_data is don't-care when out_valid=0.
- Latency: a word written at edge N is visible on out_data with out_valid=1 after edge N (one cycle from in handshake to out_valid).
- Simultaneous push and pop (not full, not empty): both occur; count unchanged.
  - When full: push blocked (in_ready=0); pop proceeds; in_ready=1 the next cycle.
  - When empty: pop impossible (out_valid=0); push proceeds.
- count: registered; +1 on push only, -1 on pop only, unchanged otherwise. Never exceeds DEPTH or underflows.
- almost_full/almost_empty: combinational compares of registered count against the parameters.
- high_water: registered; <= max(high_water, next count) each cycle.
- flush=1 (synchronous):
  - next state: pointers=0, count=0, high_water=0;
  - push/pop in that cycle are ignored;
  - in_ready remains as computed from current state.
- hwm_clear=1 (without flush): high_water <= next count.
- Priority: reset > flush > hwm_clear > normal operation.
- Assertions for the bench:
  - no push when full;
  - no pop when empty;
  - count == wr_ptr - rd_ptr (mod 2^CW).

Test Plan:
- Reset, then push 16 words 0x1..0x10 with out_ready=0:
  - count=16, in_ready=0, almost_full from the 12th word on, high_water=16;
  - a 17th word with in_valid=1 is not accepted.
- From full, out_ready=1 for 16 cycles:
  - out_data sequence 0x1..0x10;
  - in_ready=1 after the first pop;
  - count=0, out_valid=0, almost_empty=1 at the end.
- Continuous streaming (in_valid=out_ready=1) for 100 words 0..99:
  - in-order output; count stays 1 after the first word;
  - pointers wrap at least 6 times without loss.
- Fill to 5 words, assert flush for one cycle together with in_valid=1:
  - next cycle count=0, out_valid=0, high_water=0;
  - the flushed-cycle word is not stored.
- Fill to 9, drain to 3, pulse hwm_clear:
  - high_water 9 -> 3;
  - push 2 more -> high_water=5.
- With 8 words stored, assert reset low mid-cycle (asynchronously):
  - count=0, out_valid=0, in_ready=1 immediately;
  - after release, the first pushed word 0xAA appears at out_data.

Source files
------------

// File: rtl/stream_output_fifo_if.sv
// Valid/ready stream bundle used on both sides of stream_output_fifo.
//   valid : source has a word on data
//   ready : sink accepts the word this cycle
//   data  : payload, DATA_WIDTH bits
// master drives valid/data, slave drives ready.
interface stream_output_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_output_fifo.sv
// Synchronous single-clock first-word-fall-through FIFO with valid/ready on
// both sides, occupancy count, almost-full/almost-empty flags, synchronous
// flush and a clearable high-water mark.
//   clk        : clock, all state changes on rising edge
//   reset      : asynchronous active-low reset
//   flush      : synchronous clear of contents, count, pointers, high-water
//   hwm_clear  : synchronous reload of high-water mark with next count
//   in_if      : write side (slave), ready = not full
//   out_if     : read side (master), valid = not empty, data = head word
//   count      : occupancy 0..DEPTH
//   almost_full / almost_empty : count threshold flags
//   high_water : maximum count since last reset/flush/hwm_clear
module stream_output_fifo #(
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  DEPTH        = 16,
    parameter int unsigned  AFULL_LEVEL  = 12,
    parameter int unsigned  AEMPTY_LEVEL = 2,
    localparam int unsigned CW           = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  hwm_clear,
    stream_output_fifo_if.slave   in_if,
    stream_output_fifo_if.master  out_if,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         high_water
);

    localparam int unsigned AW = CW - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [CW-1:0] hwm_q,    hwm_d;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    // Status, handshakes and next-state; flush overrides any transfer.
    always_comb begin
        full_c   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty_c  = (wr_ptr_q == rd_ptr_q);
        push_c   = in_if.valid & ~full_c & ~flush;
        pop_c    = out_if.ready & ~empty_c & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hwm_d    = hwm_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hwm_d    = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
            if (hwm_clear) begin
                hwm_d = count_d;
            end else if (count_d > hwm_q) begin
                hwm_d = count_d;
            end
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Storage is not reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q[AW-1:0]] <= in_if.data;
        end
    end

    assign in_if.ready  = ~full_c;
    assign out_if.valid = ~empty_c;
    assign out_if.data  = mem[rd_ptr_q[AW-1:0]];

    assign count        = count_q;
    assign high_water   = hwm_q;
    assign almost_full  = (count_q >= CW'(AFULL_LEVEL));
    assign almost_empty = (count_q <= CW'(AEMPTY_LEVEL));

endmodule
